// File: rtl/sdram_arbiter_if.sv
// Bundles the renderer, physics and SDRAM Avalon-MM signals seen by sdram_arbiter.
// The slave modport is the arbiter's view; master is the surrounding logic's view.
interface sdram_arbiter_if #(
  parameter int ADDR_W = 24,
  parameter int DATA_W = 16
);
  logic              render_read;
  logic [ADDR_W-1:0] render_address;
  logic              render_ready;
  logic [DATA_W-1:0] render_readdata;
  logic              render_readdatavalid;

  logic              physics_read;
  logic              physics_write;
  logic [ADDR_W-1:0] physics_address;
  logic [DATA_W-1:0] physics_writedata;
  logic              physics_ready;
  logic [DATA_W-1:0] physics_readdata;
  logic              physics_readdatavalid;

  logic [ADDR_W-1:0] mem_address;
  logic              mem_read;
  logic              mem_write;
  logic [DATA_W-1:0] mem_writedata;
  logic              mem_waitrequest;
  logic              mem_readdatavalid;
  logic [DATA_W-1:0] mem_readdata;

  logic              err_orphan;

  modport slave (
    input  render_read, render_address,
    output render_ready, render_readdata, render_readdatavalid,
    input  physics_read, physics_write, physics_address, physics_writedata,
    output physics_ready, physics_readdata, physics_readdatavalid,
    output mem_address, mem_read, mem_write, mem_writedata,
    input  mem_waitrequest, mem_readdatavalid, mem_readdata,
    output err_orphan
  );

  modport master (
    output render_read, render_address,
    input  render_ready, render_readdata, render_readdatavalid,
    output physics_read, physics_write, physics_address, physics_writedata,
    input  physics_ready, physics_readdata, physics_readdatavalid,
    input  mem_address, mem_read, mem_write, mem_writedata,
    output mem_waitrequest, mem_readdatavalid, mem_readdata,
    input  err_orphan
  );
endinterface

// File: rtl/sdram_arbiter.sv
// Shares one SDRAM Avalon-MM master between the VGA renderer and the sand physics updater,
// tagging reads in an in-order FIFO so returned data is routed to its requester.
module sdram_arbiter #(
  parameter int ADDR_W    = 24,
  parameter int DATA_W    = 16,
  parameter int MAX_OUTST = 8
) (
  input  logic            clock,
  input  logic            reset_n,
  sdram_arbiter_if.slave  bus
);
  localparam int PTR_W = (MAX_OUTST > 1) ? $clog2(MAX_OUTST) : 1;
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic { IDLE, ISSUE } state_t;
  typedef enum logic { GRANT_RENDER = 1'b0, GRANT_PHYSICS = 1'b1 } grant_t;

  state_t state_q, state_d;
  grant_t last_grant;

  logic [MAX_OUTST-1:0] tag_mem;
  logic [PTR_W-1:0]     wr_ptr, rd_ptr;
  logic [CNT_W-1:0]     count;
  logic                 fifo_full;
  logic                 push, pop, orphan;

  logic render_elig, physics_elig;
  logic grant_render, grant_physics;
  logic render_ready, physics_ready;
  logic accept;

  assign fifo_full = (count == CNT_W'(MAX_OUTST));
  assign push      = (state_q == ISSUE) && !bus.mem_waitrequest && bus.mem_read;
  assign pop       = bus.mem_readdatavalid && (count != '0);
  assign orphan    = bus.mem_readdatavalid && (count == '0);

  always_ff @(posedge clock) begin
    if (!reset_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d       = state_q;
    render_ready  = 1'b0;
    physics_ready = 1'b0;
    render_elig   = bus.render_read && !fifo_full;
    physics_elig  = bus.physics_write || (bus.physics_read && !fifo_full);
    // Render wins unless physics also wants it and render was granted last.
    grant_render  = render_elig && (!physics_elig || (last_grant == GRANT_PHYSICS));
    grant_physics = physics_elig && !grant_render;
    case (state_q)
      IDLE: begin
        render_ready  = grant_render;
        physics_ready = grant_physics;
        if (grant_render || grant_physics) state_d = ISSUE;
      end
      ISSUE: begin
        if (!bus.mem_waitrequest) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign accept            = render_ready || physics_ready;
  assign bus.render_ready  = render_ready;
  assign bus.physics_ready = physics_ready;

  // Command register: loaded on accept, held through waitrequest, cleared once taken.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      bus.mem_address   <= '0;
      bus.mem_read      <= 1'b0;
      bus.mem_write     <= 1'b0;
      bus.mem_writedata <= '0;
      last_grant        <= GRANT_PHYSICS;
    end else if (state_q == IDLE && accept) begin
      if (render_ready) begin
        bus.mem_address <= bus.render_address;
        bus.mem_read    <= 1'b1;
        bus.mem_write   <= 1'b0;
        last_grant      <= GRANT_RENDER;
      end else begin
        bus.mem_address   <= bus.physics_address;
        bus.mem_read      <= !bus.physics_write;
        bus.mem_write     <= bus.physics_write;
        bus.mem_writedata <= bus.physics_writedata;
        last_grant        <= GRANT_PHYSICS;
      end
    end else if (state_q == ISSUE && !bus.mem_waitrequest) begin
      bus.mem_read  <= 1'b0;
      bus.mem_write <= 1'b0;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      tag_mem <= '0;
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
    end else begin
      if (push) begin
        tag_mem[wr_ptr] <= (last_grant == GRANT_PHYSICS);
        wr_ptr          <= wr_ptr + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      if (push && !pop)      count <= count + 1'b1;
      else if (pop && !push) count <= count - 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      bus.render_readdata       <= '0;
      bus.render_readdatavalid  <= 1'b0;
      bus.physics_readdata      <= '0;
      bus.physics_readdatavalid <= 1'b0;
      bus.err_orphan            <= 1'b0;
    end else begin
      bus.render_readdatavalid  <= 1'b0;
      bus.physics_readdatavalid <= 1'b0;
      if (pop) begin
        if (tag_mem[rd_ptr]) begin
          bus.physics_readdata      <= bus.mem_readdata;
          bus.physics_readdatavalid <= 1'b1;
        end else begin
          bus.render_readdata      <= bus.mem_readdata;
          bus.render_readdatavalid <= 1'b1;
        end
      end
      if (orphan) bus.err_orphan <= 1'b1;
    end
  end
endmodule
